// File: rtl/fpu_cmd_master_pkg.sv
// Shared definitions for the FPU command master: UART command bytes,
// 23-bit float field layout and FSM state encoding.
package fpu_cmd_master_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned FP_W      = 23;
  localparam int unsigned EXP_W     = 7;
  localparam int unsigned MANT_W    = 15;
  localparam int unsigned SIGN_BIT  = 22;
  localparam int unsigned EXP_LSB   = 15;
  localparam int unsigned MANT_HI_W = 8;
  localparam int unsigned MANT_LO_W = 7;
  localparam int unsigned CNT_W     = 20;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned SEL_W     = 2;

  localparam logic [BYTE_W-1:0] CMD_SETR1  = 8'h81;
  localparam logic [BYTE_W-1:0] CMD_SETR2  = 8'h82;
  localparam logic [BYTE_W-1:0] CMD_READR1 = 8'h84;
  localparam logic [BYTE_W-1:0] CMD_READR2 = 8'h88;
  localparam logic [BYTE_W-1:0] CMD_READRS = 8'h90;
  localparam logic [BYTE_W-1:0] CMD_ADD    = 8'hA0;
  localparam logic [BYTE_W-1:0] CMD_SUB    = 8'hC0;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SEND_OPS = 3'd1;
  localparam logic [2:0] ST_SETTLE   = 3'd2;
  localparam logic [2:0] ST_SEND_RD  = 3'd3;
  localparam logic [2:0] ST_RECV     = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp23_t;

endpackage

// File: rtl/fpu_word_ser.sv
// Maps a 23-bit float word and a byte select (0..2) to the byte sent on the UART.
module fpu_word_ser
  import fpu_cmd_master_pkg::*;
(
  input  logic [FP_W-1:0]   i_word,
  input  logic [SEL_W-1:0]  i_sel,
  output logic [BYTE_W-1:0] o_byte_c
);

  fp23_t w_f;

  assign w_f = fp23_t'(i_word);

  always_comb begin
    o_byte_c = '0;
    case (i_sel)
      2'd0:    o_byte_c = {w_f.sign, w_f.exp};
      2'd1:    o_byte_c = w_f.mant[MANT_W-1:MANT_LO_W];
      2'd2:    o_byte_c = {w_f.mant[MANT_LO_W-1:0], 1'b0};
      default: o_byte_c = '0;
    endcase
  end

endmodule

// File: rtl/fpu_cmd_master.sv
// Drives one add/sub on a UART-attached FPU: sends operands and op, waits,
// requests the result and assembles the three returned bytes.
module fpu_cmd_master
  import fpu_cmd_master_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1048575
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              op_sub,
  input  logic [FP_W-1:0]   a_in,
  input  logic [FP_W-1:0]   b_in,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic [FP_W-1:0]   result,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_OP      = IDX_W'(8);

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_rx_idx;
  logic [FP_W-1:0]   r_a;
  logic [FP_W-1:0]   r_b;
  logic              r_sub;
  logic [BYTE_W-1:0] r_rx_se;
  logic [BYTE_W-1:0] r_rx_mh;
  logic [BYTE_W-1:0] r_tx_data;
  logic              r_tx_valid;
  logic [FP_W-1:0]   r_result;
  logic              r_busy;
  logic              r_done;
  logic              r_timeout;

  logic              w_xfer;
  logic              w_sending;
  logic              w_rx_acc;
  logic              w_rx_last;
  logic              w_to_hit;
  logic [FP_W-1:0]   w_ser_word;
  logic [SEL_W-1:0]  w_ser_sel;
  logic [BYTE_W-1:0] w_ser_byte;
  logic [BYTE_W-1:0] w_tx_byte;

  assign w_xfer    = r_tx_valid & tx_ready;
  assign w_sending = (r_state == ST_SEND_OPS) | (r_state == ST_SEND_RD);
  assign w_rx_acc  = (r_state == ST_RECV) & rx_valid;
  assign w_rx_last = w_rx_acc & (r_rx_idx == 2'd2);
  // An rx byte arriving on the last wait cycle wins over the timeout.
  assign w_to_hit  = (r_state == ST_RECV) & ~rx_valid & (r_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (start) w_state_nxt = ST_SEND_OPS;
      ST_SEND_OPS: if (w_xfer && (r_idx == IDX_OP)) w_state_nxt = ST_SETTLE;
      ST_SETTLE:   if (r_cnt == SETTLE_LAST) w_state_nxt = ST_SEND_RD;
      ST_SEND_RD:  if (w_xfer) w_state_nxt = ST_RECV;
      ST_RECV:     if (w_rx_last || w_to_hit) w_state_nxt = ST_DONE;
      ST_DONE:     w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Byte index 0..9 selects a command byte or an operand field.
  always_comb begin
    w_ser_word = r_a;
    w_ser_sel  = '0;
    case (r_idx)
      4'd1, 4'd2, 4'd3: w_ser_sel = SEL_W'(r_idx - 4'd1);
      4'd5, 4'd6, 4'd7: begin
        w_ser_word = r_b;
        w_ser_sel  = SEL_W'(r_idx - 4'd5);
      end
      default: w_ser_sel = '0;
    endcase
  end

  always_comb begin
    w_tx_byte = w_ser_byte;
    case (r_idx)
      4'd0:    w_tx_byte = CMD_SETR1;
      4'd4:    w_tx_byte = CMD_SETR2;
      4'd8:    w_tx_byte = r_sub ? CMD_SUB : CMD_ADD;
      4'd9:    w_tx_byte = CMD_READRS;
      default: w_tx_byte = w_ser_byte;
    endcase
  end

  fpu_word_ser u_ser (
    .i_word   (w_ser_word),
    .i_sel    (w_ser_sel),
    .o_byte_c (w_ser_byte)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx      <= '0;
      r_cnt      <= '0;
      r_rx_idx   <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_sub      <= 1'b0;
      r_rx_se    <= '0;
      r_rx_mh    <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_result   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_done    <= (w_state_nxt == ST_DONE);
      r_timeout <= (w_state_nxt == ST_DONE) & w_to_hit;

      if ((r_state == ST_IDLE) && start) begin
        r_a      <= a_in;
        r_b      <= b_in;
        r_sub    <= op_sub;
        r_idx    <= '0;
        r_rx_idx <= '0;
      end

      // Present a byte, hold it until accepted, then leave one idle cycle.
      if (w_sending) begin
        if (r_tx_valid) begin
          if (tx_ready) begin
            r_tx_valid <= 1'b0;
            r_idx      <= r_idx + IDX_W'(1);
          end
        end else begin
          r_tx_valid <= 1'b1;
          r_tx_data  <= w_tx_byte;
        end
      end

      if ((w_state_nxt != r_state) || w_rx_acc)
        r_cnt <= '0;
      else if ((r_state == ST_SETTLE) || (r_state == ST_RECV))
        r_cnt <= r_cnt + CNT_W'(1);

      if (w_rx_acc) begin
        r_rx_idx <= r_rx_idx + 2'd1;
        case (r_rx_idx)
          2'd0:    r_rx_se <= rx_data;
          2'd1:    r_rx_mh <= rx_data;
          default: r_rx_se <= r_rx_se;
        endcase
      end

      if (w_rx_last)
        r_result <= {r_rx_se, r_rx_mh, rx_data[BYTE_W-1:1]};
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign result   = r_result;
  assign busy     = r_busy;
  assign done     = r_done;
  assign timeout  = r_timeout;

endmodule
